// File: rtl/counter_seq_pkg.sv
// Shared definitions for the 4-bit counter sequencer.
// Holds the command opcode encoding, the sequencer state encoding and the
// default sizing constants used by counter4_sequencer and its readback checker.
package counter_seq_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_CMP_LAT = 2;

    typedef enum logic [1:0] {
        OP_NOP         = 2'b00,
        OP_COUNT       = 2'b01,
        OP_CLEAR       = 2'b10,
        OP_CLEAR_COUNT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CLR  = 2'b01,
        S_CNT  = 2'b10,
        S_WAIT = 2'b11
    } state_e;

endpackage

// File: rtl/counter4_sequencer_checker.sv
// counter_readback_checker: settle timer plus sticky compare flag.
// While the sequencer sits in WAIT, the timer counts CMP_LAT cycles. On the
// edge that ends the last WAIT cycle the counter readback is compared with the
// shadow count (only when the shadow is known-good) and a difference sets the
// sticky mismatch flag. A set on the same edge as a clear wins.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_wait         sequencer is in its WAIT state
//   synced          shadow count is valid
//   count_in        counter readback
//   shadow          expected counter value
//   mismatch_clr    clears the sticky flag
//   wait_last       current cycle is the last WAIT cycle (combinational)
//   mismatch        registered sticky compare-failure flag
module counter_readback_checker
    import counter_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CMP_LAT = DEF_CMP_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_wait,
    input  logic             synced,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] shadow,
    input  logic             mismatch_clr,
    output logic             wait_last,
    output logic             mismatch
);

    localparam int TW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CMP_LAT - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          mismatch_q;
    logic          mismatch_d;
    logic          cmp_fail_s;
    logic          wait_last_s;

    assign wait_last_s = in_wait && (timer_q == LAST);
    assign wait_last   = wait_last_s;
    assign mismatch    = mismatch_q;

    // Settle timer and compare/sticky-flag next-state logic.
    always_comb begin
        timer_d    = timer_q;
        mismatch_d = mismatch_q;
        cmp_fail_s = 1'b0;
        if (wait_last_s) begin
            timer_d    = '0;
            cmp_fail_s = synced && (count_in != shadow);
        end else if (in_wait) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = '0;
        end
        if (cmp_fail_s) begin
            mismatch_d = 1'b1;
        end else if (mismatch_clr) begin
            mismatch_d = 1'b0;
        end else begin
            mismatch_d = mismatch_q;
        end
    end

    // Timer and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            mismatch_q <= mismatch_d;
        end
    end

endmodule

// File: rtl/counter4_sequencer.sv
// counter4_sequencer: command-driven controller for a 4-bit pulse counter.
// Accepts CLEAR / COUNT-N commands over valid/ready, issues single-cycle
// rst/en pulses, tracks the expected count in a shadow register and checks
// the counter readback after a settle window.
// Ports:
//   GCLK_Pad, rstn_Pad        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op, cmd_len           opcode and burst length, captured at acceptance
//   count_Pad                 counter readback
//   en_Pad, rst_Pad           registered pulses to the counter
//   busy, done                not-IDLE status, one-cycle completion pulse
//   shadow_count, synced      expected count and its validity
//   mismatch, mismatch_clr    sticky compare-failure flag and its clear
// All pulse-side effects (shadow update, synced) are computed from the next
// state so they become visible in the same cycle as the matching pulse.
module counter4_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CMP_LAT = DEF_CMP_LAT
) (
    input  logic             GCLK_Pad,
    input  logic             rstn_Pad,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] count_Pad,
    output logic             en_Pad,
    output logic             rst_Pad,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow_count,
    output logic             synced,
    output logic             mismatch,
    input  logic             mismatch_clr
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             synced_q, synced_d;
    logic             en_q, en_d;
    logic             rst_q, rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             wait_last_s;

    // Next-state, shadow tracking and registered-output logic.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pend_d      = pend_q;
        shadow_d    = shadow_q;
        synced_d    = synced_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        OP_COUNT: begin
                            pend_d      = 1'b0;
                            remaining_d = cmd_len;
                            state_d     = (cmd_len != '0) ? S_CNT : S_WAIT;
                        end
                        OP_CLEAR: begin
                            pend_d      = 1'b0;
                            remaining_d = '0;
                            state_d     = S_CLR;
                        end
                        OP_CLEAR_COUNT: begin
                            pend_d      = 1'b1;
                            remaining_d = cmd_len;
                            state_d     = S_CLR;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                pend_d  = 1'b0;
                state_d = (pend_q && (remaining_q != '0)) ? S_CNT : S_WAIT;
            end
            S_CNT: begin
                // remaining_q includes the pulse being driven this cycle.
                remaining_d = remaining_q - LEN_W'(1);
                if (remaining_q <= LEN_W'(1)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CNT;
                end
            end
            S_WAIT: begin
                if (wait_last_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shadow moves together with the pulse that causes the change.
        if (state_d == S_CLR) begin
            shadow_d = '0;
            synced_d = 1'b1;
        end else if (state_d == S_CNT) begin
            shadow_d = shadow_q + WIDTH'(1);
        end else begin
            shadow_d = shadow_q;
        end

        en_d    = (state_d == S_CNT);
        rst_d   = (state_d == S_CLR);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
        done_d  = (state_q == S_WAIT) && (state_d == S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge GCLK_Pad or negedge rstn_Pad) begin
        if (!rstn_Pad) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            pend_q      <= 1'b0;
            shadow_q    <= '0;
            synced_q    <= 1'b0;
            en_q        <= 1'b0;
            rst_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pend_q      <= pend_d;
            shadow_q    <= shadow_d;
            synced_q    <= synced_d;
            en_q        <= en_d;
            rst_q       <= rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    counter_readback_checker #(
        .WIDTH   (WIDTH),
        .CMP_LAT (CMP_LAT)
    ) u_checker (
        .clk          (GCLK_Pad),
        .rst_n        (rstn_Pad),
        .in_wait      (state_q == S_WAIT),
        .synced       (synced_q),
        .count_in     (count_Pad),
        .shadow       (shadow_q),
        .mismatch_clr (mismatch_clr),
        .wait_last    (wait_last_s),
        .mismatch     (mismatch)
    );

    assign cmd_ready    = ready_q;
    assign en_Pad       = en_q;
    assign rst_Pad      = rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign shadow_count = shadow_q;
    assign synced       = synced_q;

endmodule

// File: tb/tb_counter4_sequencer.sv
// Directed testbench for counter4_sequencer. A behavioural 4-bit counter
// reacts to en_Pad/rst_Pad and feeds count_Pad; an override lets the bench
// present a wrong readback. Expected cycle timing comes from the command
// latency rules (rst in cycle 1 for clearing ops, en for the next N cycles,
// CMP_LAT wait cycles, then done).
module tb_counter4_sequencer;

    localparam int CMP_LAT = 2;

    logic       GCLK_Pad;
    logic       rstn_Pad;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_len;
    logic [3:0] count_Pad;
    logic       en_Pad;
    logic       rst_Pad;
    logic       busy;
    logic       done;
    logic [3:0] shadow_count;
    logic       synced;
    logic       mismatch;
    logic       mismatch_clr;

    logic [3:0] model_cnt;
    logic       ovr_en;
    logic [3:0] ovr_val;

    int n_total;
    int n_bad;

    counter4_sequencer #(
        .WIDTH   (4),
        .LEN_W   (8),
        .CMP_LAT (CMP_LAT)
    ) dut (
        .GCLK_Pad     (GCLK_Pad),
        .rstn_Pad     (rstn_Pad),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_len      (cmd_len),
        .count_Pad    (count_Pad),
        .en_Pad       (en_Pad),
        .rst_Pad      (rst_Pad),
        .busy         (busy),
        .done         (done),
        .shadow_count (shadow_count),
        .synced       (synced),
        .mismatch     (mismatch),
        .mismatch_clr (mismatch_clr)
    );

    initial GCLK_Pad = 1'b0;
    always #5 GCLK_Pad = ~GCLK_Pad;

    // External counter driven by the sequencer pulses.
    always @(posedge GCLK_Pad or negedge rstn_Pad) begin
        if (!rstn_Pad)    model_cnt <= 4'd0;
        else if (rst_Pad) model_cnt <= 4'd0;
        else if (en_Pad)  model_cnt <= model_cnt + 4'd1;
    end

    assign count_Pad = ovr_en ? ovr_val : model_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge GCLK_Pad);
        #1;
    endtask

    // Issue one command and check every cycle up to and including done.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] len, input bit hold,
                           input logic [3:0] base, input bit exp_sync, input bit exp_mis);
        int off;
        int n;
        int fin;
        logic [3:0] b;
        logic [3:0] exp_sh;
        off = (op == 2'b10 || op == 2'b11) ? 1 : 0;
        n   = (op == 2'b01 || op == 2'b11) ? int'(len) : 0;
        b   = (off == 1) ? 4'd0 : base;
        fin = off + n + CMP_LAT + 1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        for (int c = 1; c <= fin; c++) begin
            step();
            if (!hold || c == fin) cmd_valid = 1'b0;
            if (hold) cmd_len = 8'd5;
            check_eq($sformatf("op%0d rst c%0d", op, c), rst_Pad, (off == 1 && c == 1));
            check_eq($sformatf("op%0d en c%0d", op, c), en_Pad, (c > off && c <= off + n));
            check_eq($sformatf("op%0d done c%0d", op, c), done, (c == fin));
            check_eq($sformatf("op%0d busy c%0d", op, c), busy, (c != fin));
            check_eq($sformatf("op%0d ready c%0d", op, c), cmd_ready, (c == fin));
            if (c > off && c <= off + n) begin
                exp_sh = b + 4'(c - off);
                check_eq($sformatf("op%0d shadow c%0d", op, c), shadow_count, exp_sh);
            end
        end
        exp_sh = b + 4'(n);
        check_eq("final shadow", shadow_count, exp_sh);
        check_eq("final synced", synced, exp_sync);
        check_eq("final mismatch", mismatch, exp_mis);
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rstn_Pad     = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_len      = 8'd0;
        mismatch_clr = 1'b0;
        ovr_en       = 1'b0;
        ovr_val      = 4'd0;

        // Reset state
        #2;
        check_eq("rst en", en_Pad, 1'b0);
        check_eq("rst rstpad", rst_Pad, 1'b0);
        check_eq("rst busy", busy, 1'b0);
        check_eq("rst done", done, 1'b0);
        check_eq("rst mismatch", mismatch, 1'b0);
        check_eq("rst synced", synced, 1'b0);
        check_eq("rst shadow", shadow_count, 4'd0);
        step();
        rstn_Pad = 1'b1;
        step();
        check_eq("rst ready", cmd_ready, 1'b1);

        // CLEAR
        run_cmd(2'b10, 8'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        // CLEAR_COUNT 3, correct readback
        run_cmd(2'b11, 8'd3, 1'b0, 4'd0, 1'b1, 1'b0);
        // CLEAR_COUNT 3, readback forced to 2
        ovr_en  = 1'b1;
        ovr_val = 4'd2;
        run_cmd(2'b11, 8'd3, 1'b0, 4'd0, 1'b1, 1'b1);
        ovr_en       = 1'b0;
        mismatch_clr = 1'b1;
        step();
        mismatch_clr = 1'b0;
        check_eq("mis cleared", mismatch, 1'b0);

        // Wrap: shadow 14 then COUNT 3 -> 15,0,1
        run_cmd(2'b11, 8'd14, 1'b0, 4'd0, 1'b1, 1'b0);
        run_cmd(2'b01, 8'd3, 1'b0, 4'd14, 1'b1, 1'b0);
        // Clear held during a new mismatch: set wins
        ovr_en       = 1'b1;
        ovr_val      = 4'd7;
        mismatch_clr = 1'b1;
        run_cmd(2'b01, 8'd1, 1'b0, 4'd1, 1'b1, 1'b1);
        ovr_en = 1'b0;
        step();
        mismatch_clr = 1'b0;
        check_eq("mis clr after set", mismatch, 1'b0);

        // COUNT len 0
        run_cmd(2'b01, 8'd0, 1'b0, 4'd2, 1'b1, 1'b0);
        // NOP
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_len   = 8'd4;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("nop done %0d", i), done, 1'b0);
            check_eq($sformatf("nop ready %0d", i), cmd_ready, 1'b1);
            check_eq($sformatf("nop en %0d", i), en_Pad, 1'b0);
            step();
        end
        // cmd_valid held while busy is not accepted
        run_cmd(2'b01, 8'd2, 1'b1, 4'd2, 1'b1, 1'b0);

        // Unsynced COUNT 5 after reset, readback 9
        rstn_Pad = 1'b0;
        step();
        step();
        rstn_Pad = 1'b1;
        check_eq("rst2 synced", synced, 1'b0);
        check_eq("rst2 shadow", shadow_count, 4'd0);
        ovr_en  = 1'b1;
        ovr_val = 4'd9;
        run_cmd(2'b01, 8'd5, 1'b0, 4'd0, 1'b0, 1'b0);
        ovr_en = 1'b0;

        // Mid-CNT reset
        run_cmd(2'b10, 8'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_len   = 8'd6;
        for (int c = 1; c <= 2; c++) begin
            step();
            cmd_valid = 1'b0;
            check_eq($sformatf("abort en c%0d", c), en_Pad, 1'b1);
        end
        #3;
        rstn_Pad = 1'b0;
        #1;
        check_eq("abort en", en_Pad, 1'b0);
        check_eq("abort busy", busy, 1'b0);
        check_eq("abort shadow", shadow_count, 4'd0);
        check_eq("abort synced", synced, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq($sformatf("abort done %0d", i), done, 1'b0);
        end
        rstn_Pad = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("post ready %0d", i), cmd_ready, 1'b1);
            check_eq($sformatf("post done %0d", i), done, 1'b0);
            check_eq($sformatf("post en %0d", i), en_Pad, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
